muxd_pipe: RTL and testbench

- Parametrised successor to the 3-way 16-bit datapath mux: an N_IN-way, DATA_W-bit selector with a registered output and a valid/ready handshake on both sides.
- A 2-entry skid buffer decouples producer from consumer, so in_ready is a registered signal.
- Out-of-range selects are detected and flagged with a sticky error.
- Sits between the register-file/ALU/immediate sources and the writeback or operand latch.

---
 rtl/mycpu_pkg.sv | 15 +
 rtl/muxd_skid_buf.sv | 66 ++++++
 rtl/muxd_pipe.sv | 81 ++++++++
 tb/tb_muxd_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU package: clock period and the types used by the datapath selector.
package mycpu_pkg;

    localparam int CLK_PERIOD  = 10;
    localparam int MUXD_MAX_IN = 16;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } muxd_buf_state_t;

endpackage

// File: rtl/muxd_skid_buf.sv
// Two-entry skid buffer: main register drives the consumer, skid catches one extra word.
module muxd_skid_buf
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] m_out,
    output muxd_buf_state_t   state
);

    // Handshake: a word moves on an edge where valid and ready are both high;
    // the producer only pushes while the buffer is not TWO.
    muxd_buf_state_t  state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              pop;

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (push) state_d = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_d = BUF_TWO;
                else if (!push && pop) state_d = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q != BUF_EMPTY);
        m_out     = main_q;
        state     = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: if (push) main_q <= push_data;
                BUF_ONE: begin
                    if (push && pop)  main_q <= push_data;
                    else if (push)    skid_q <= push_data;
                end
                BUF_TWO:   if (pop) main_q <= skid_q;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/muxd_pipe.sv
// N_IN-way registered selector with valid/ready handshake and sticky select error.
// Optional pop counter output xfer_cnt enabled by MUXD_PIPE_XFER_CNT_EN.
module muxd_pipe
    import mycpu_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int N_IN   = 3,
    localparam int SEL_W  = $clog2(N_IN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEL_W-1:0]            sel_in,
    input  logic [N_IN-1:0][DATA_W-1:0] d_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           m_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err,
    input  logic                        err_clr
`ifdef MUXD_PIPE_XFER_CNT_EN
    ,
    output logic [15:0]                 xfer_cnt
`endif
);

    // With a power-of-two channel count every select value is legal.
    localparam bit SEL_CHECK = (N_IN != (1 << SEL_W));

    muxd_buf_state_t   buf_state;
    logic              accept;
    logic              sel_oor;
    logic [DATA_W-1:0] push_data;

    // buf_state is a register, so in_ready never sees out_ready combinationally.
    assign in_ready = (buf_state != BUF_TWO);
    assign accept   = in_valid && in_ready;

    always_comb begin
        push_data = '0;
        sel_oor   = 1'b0;
        if (SEL_CHECK && (int'(sel_in) >= N_IN)) sel_oor   = 1'b1;
        else                                     push_data = d_in[sel_in];
    end

    muxd_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .m_out     (m_out),
        .state     (buf_state)
    );

    generate
        if (SEL_CHECK) begin : g_sel_err
            logic sel_err_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                  sel_err_q <= 1'b0;
                else if (accept && sel_oor)  sel_err_q <= 1'b1;
                else if (err_clr)            sel_err_q <= 1'b0;
            end
            assign sel_err = sel_err_q;
        end else begin : g_no_sel_err
            assign sel_err = 1'b0;
        end
    endgenerate

`ifdef MUXD_PIPE_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          xfer_cnt_q <= '0;
        else if (err_clr)                                    xfer_cnt_q <= '0;
        else if (out_valid && out_ready && xfer_cnt_q != 16'hFFFF) xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_muxd_pipe.sv
// Directed bench for muxd_pipe (N_IN=3, DATA_W=16).
module tb_muxd_pipe;
    import mycpu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       sel_in;
    logic [2:0][15:0] d_in;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      m_out;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;
    logic             err_clr;
`ifdef MUXD_PIPE_XFER_CNT_EN
    logic [15:0]      xfer_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    always #(CLK_PERIOD/2) clk = ~clk;

    muxd_pipe #(.DATA_W(16), .N_IN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_in    (sel_in),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_out     (m_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
`ifdef MUXD_PIPE_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        sel_in = '0; d_in = '0;
        #3;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ov got %0b want 0", out_valid); end
        vectors++; if (m_out !== 16'h0) begin miscompares++; $display("FAIL reset_m_out got %h want 0000", m_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ir got %0b want 1", in_ready); end
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", sel_err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        out_ready = 1'b1;
        d_in = {16'h3333, 16'h2222, 16'h1111};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_in = 2'(i);
            tick();
            vectors++; if (m_out !== exp_w[i] || out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_%0d got %h/%0b want %h/1", i, m_out, out_valid, exp_w[i]); end
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ir_%0d got %0b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; sel_in = 2'd0;
        d_in[0] = 16'hA0A0; tick();
        vectors++; if (m_out !== 16'hA0A0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_one got %h/%0b want a0a0/1", m_out, in_ready); end
        d_in[0] = 16'hB0B0; tick();
        vectors++; if (in_ready !== 1'b0 || m_out !== 16'hA0A0) begin miscompares++; $display("FAIL bp_two got %h/%0b want a0a0/0", m_out, in_ready); end
        vectors++; if (dut.u_buf.state !== BUF_TWO) begin miscompares++; $display("FAIL bp_state got %0d want 2", dut.u_buf.state); end
        d_in[0] = 16'hC0C0; tick();
        vectors++; if (in_ready !== 1'b0 || m_out !== 16'hA0A0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold got %h/%0b want a0a0/0", m_out, in_ready); end
        out_ready = 1'b1; tick();
        vectors++; if (m_out !== 16'hB0B0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_pop1 got %h/%0b want b0b0/1", m_out, in_ready); end
        tick();
        vectors++; if (m_out !== 16'hC0C0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_c got %h/%0b want c0c0/1", m_out, out_valid); end
        in_valid = 1'b0; tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1; in_valid = 1'b1; sel_in = 2'd3;
        d_in = {16'h3333, 16'h2222, 16'h1111};
        tick();
        vectors++; if (m_out !== 16'h0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL oor_data got %h/%0b want 0000/1", m_out, out_valid); end
        vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL oor_set got %0b want 1", sel_err); end
        in_valid = 1'b0; tick(); tick();
        vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL oor_hold got %0b want 1", sel_err); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL oor_clr got %0b want 0", sel_err); end
        in_valid = 1'b1; sel_in = 2'd2; tick();
        vectors++; if (sel_err !== 1'b0 || m_out !== 16'h3333) begin miscompares++; $display("FAIL oor_legal got %0b/%h want 0/3333", sel_err, m_out); end
        err_clr = 1'b1; sel_in = 2'd3; tick();
        vectors++; if (sel_err !== 1'b1) begin miscompares++; $display("FAIL oor_set_wins got %0b want 1", sel_err); end
        in_valid = 1'b0; tick(); err_clr = 1'b0;
        vectors++; if (sel_err !== 1'b0) begin miscompares++; $display("FAIL oor_clr2 got %0b want 0", sel_err); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w;
        out_ready = 1'b1; in_valid = 1'b1; sel_in = 2'd1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            d_in[1] = 16'h1000 + 16'(i * 16'h0111);
            exp_q.push_back(d_in[1]);
            tick();
            exp_w = exp_q.pop_front();
            vectors++; if (m_out !== exp_w || out_valid !== 1'b1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_%0d got %h/%0b/%0b want %h/1/1", i, m_out, out_valid, in_ready, exp_w); end
            vectors++; if (dut.u_buf.state !== BUF_ONE) begin miscompares++; $display("FAIL b2b_state_%0d got %0d want 1", i, dut.u_buf.state); end
        end
        in_valid = 1'b0; tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1; sel_in = 2'd0;
        d_in[0] = 16'h5A5A; tick();
        d_in[0] = 16'h6B6B; tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mr_two got %0b want 0", in_ready); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || m_out !== 16'h0) begin miscompares++; $display("FAIL mr_async got %0b/%0b/%h want 0/1/0000", out_valid, in_ready, m_out); end
        tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || m_out !== 16'h0) begin miscompares++; $display("FAIL mr_release got %0b/%h want 0/0000", out_valid, m_out); end
    endtask

`ifdef MUXD_PIPE_XFER_CNT_EN
    task automatic test_xfer_cnt();
        err_clr = 1'b1; in_valid = 1'b0; tick(); err_clr = 1'b0;
        vectors++; if (xfer_cnt !== 16'h0) begin miscompares++; $display("FAIL cnt_clr0 got %h want 0000", xfer_cnt); end
        out_ready = 1'b1; in_valid = 1'b1; sel_in = 2'd0;
        for (int i = 0; i < 5; i++) begin
            d_in[0] = 16'(i + 1);
            tick();
        end
        in_valid = 1'b0; tick();
        vectors++; if (xfer_cnt !== 16'd5) begin miscompares++; $display("FAIL cnt_five got %h want 0005", xfer_cnt); end
        force dut.xfer_cnt_q = 16'hFFFF;
        #1 release dut.xfer_cnt_q;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        vectors++; if (xfer_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_sat got %h want ffff", xfer_cnt); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        vectors++; if (xfer_cnt !== 16'h0) begin miscompares++; $display("FAIL cnt_clr got %h want 0000", xfer_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_mid_reset();
`ifdef MUXD_PIPE_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
